ascon_output_fifo: RTL and testbench

Parametrised output buffer for the Ascon-AEAD128 datapath. It captures ciphertext, plaintext and tag words from the core on single-cycle enable strobes and queues up to DEPTH words. Words are presented to the bus-side register interface with a valid/ready handshake. Compared with the single-register output stage it adds configurable depth, back-pressure, fill-level reporting, a sticky overflow flag and a flush. It sits between the Ascon permutation/mode controller and the subsystem's APB register file.

---
 rtl/ascon_pkg.sv | 13 +
 rtl/ascon_fifo_ptr.sv | 42 ++++
 rtl/ascon_output_fifo.sv | 62 ++++++
 tb/tb_ascon_output_fifo.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/ascon_pkg.sv
// Shared constants and helpers for the Ascon datapath blocks.
package ascon_pkg;

    localparam int ASCON_OUT_DEPTH_DEFAULT = 4;

    // Wrap-around increment. DEPTH need not be a power of two, so the
    // pointer cannot simply roll over on its own width.
    function automatic logic [31:0] ascon_ptr_inc(input logic [31:0] ptr,
                                                  input logic [31:0] depth);
        return (ptr == depth - 32'd1) ? 32'd0 : ptr + 32'd1;
    endfunction

endpackage

// File: rtl/ascon_fifo_ptr.sv
// Pointer/count controller for the Ascon output FIFO.
module ascon_fifo_ptr
    import ascon_pkg::*;
#(
    parameter int DEPTH = ASCON_OUT_DEPTH_DEFAULT,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush_i,
    input  logic             en_i,
    input  logic             ready_i,
    output logic             push_ok,
    output logic             pop_ok,
    output logic [PTR_W-1:0] wr_ptr,
    output logic [PTR_W-1:0] rd_ptr,
    output logic [CNT_W-1:0] count
);

    logic full;

    assign full = (count == CNT_W'(DEPTH));

    // Flush overrides both sides; a pop frees a slot for a write at full.
    assign pop_ok  = !flush_i && ready_i && (count != '0);
    assign push_ok = !flush_i && en_i && (!full || pop_ok);

    always_ff @(posedge clk) begin
        if (!rst_n || flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= PTR_W'(ascon_ptr_inc(32'(wr_ptr), 32'(DEPTH)));
            if (pop_ok)  rd_ptr <= PTR_W'(ascon_ptr_inc(32'(rd_ptr), 32'(DEPTH)));
            if (push_ok && !pop_ok)      count <= count + CNT_W'(1);
            else if (pop_ok && !push_ok) count <= count - CNT_W'(1);
        end
    end

endmodule

// File: rtl/ascon_output_fifo.sv
// Output buffer between the Ascon mode controller and the APB register file.
module ascon_output_fifo
    import ascon_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int DEPTH = ASCON_OUT_DEPTH_DEFAULT,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             flush_i,
    output logic [WIDTH-1:0] data_o,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [CNT_W-1:0] level_o,
    output logic             overflow_o,
    output logic             valid_pulse_o
);

    logic             push_ok;
    logic             pop_ok;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] mem [DEPTH];

    ascon_fifo_ptr #(.DEPTH(DEPTH)) u_ptr (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (flush_i),
        .en_i    (en_i),
        .ready_i (ready_i),
        .push_ok (push_ok),
        .pop_ok  (pop_ok),
        .wr_ptr  (wr_ptr),
        .rd_ptr  (rd_ptr),
        .count   (count)
    );

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= data_i;
    end

    // A write that is neither flushed nor accepted can only be a drop at full.
    always_ff @(posedge clk) begin
        if (!rst_n || flush_i) begin
            overflow_o    <= 1'b0;
            valid_pulse_o <= 1'b0;
        end else begin
            if (en_i && !push_ok) overflow_o <= 1'b1;
            valid_pulse_o <= push_ok;
        end
    end

    assign valid_o = (count != '0);
    assign level_o = count;
    assign data_o  = valid_o ? mem[rd_ptr] : '0;

endmodule

// File: tb/tb_ascon_output_fifo.sv
// Directed bench for ascon_output_fifo: DEPTH=4 main instance, DEPTH=3 wrap instance.
module tb_ascon_output_fifo;

    logic        clk = 1'b0;
    logic        rst_n;
    int          n_chk = 0;
    int          n_pass = 0;

    logic        en_a, flush_a, ready_a, valid_a, ovf_a, pulse_a;
    logic [63:0] din_a, dout_a;
    logic [2:0]  lvl_a;

    logic        en_b, flush_b, ready_b, valid_b, ovf_b, pulse_b;
    logic [63:0] din_b, dout_b;
    logic [1:0]  lvl_b;

    always #5 clk = ~clk;

    ascon_output_fifo #(.WIDTH(64), .DEPTH(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .en_i(en_a), .data_i(din_a), .flush_i(flush_a),
        .data_o(dout_a), .valid_o(valid_a), .ready_i(ready_a), .level_o(lvl_a),
        .overflow_o(ovf_a), .valid_pulse_o(pulse_a)
    );

    ascon_output_fifo #(.WIDTH(64), .DEPTH(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .en_i(en_b), .data_i(din_b), .flush_i(flush_b),
        .data_o(dout_b), .valid_o(valid_b), .ready_i(ready_b), .level_o(lvl_b),
        .overflow_o(ovf_b), .valid_pulse_o(pulse_b)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_a(input logic [63:0] d);
        en_a = 1'b1; din_a = d;
        step();
        chk("push_pulse", 64'(pulse_a), 64'd1);
        en_a = 1'b0;
    endtask

    task automatic drain_a(input logic [63:0] w0, input logic [63:0] w1,
                           input logic [63:0] w2, input logic [63:0] w3);
        logic [63:0] exp_w [4];
        exp_w = '{w0, w1, w2, w3};
        ready_a = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("drain_data", dout_a, exp_w[i]);
            chk("drain_valid", 64'(valid_a), 64'd1);
            step();
        end
        ready_a = 1'b0;
        chk("drained_valid", 64'(valid_a), 64'd0);
        chk("drained_data", dout_a, 64'd0);
        chk("drained_level", 64'(lvl_a), 64'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        en_a = 1'b1; din_a = 64'h99; flush_a = 1'b0; ready_a = 1'b0;
        en_b = 1'b0; din_b = '0;     flush_b = 1'b0; ready_b = 1'b0;

        // Reset held two cycles with a write strobe present
        for (int i = 0; i < 2; i++) begin
            step();
            chk("rst_pulse", 64'(pulse_a), 64'd0);
        end
        rst_n = 1'b1; en_a = 1'b0;
        step();
        chk("rst_level", 64'(lvl_a), 64'd0);
        chk("rst_valid", 64'(valid_a), 64'd0);
        chk("rst_data", dout_a, 64'd0);
        chk("rst_ovf", 64'(ovf_a), 64'd0);
        chk("rst_pulse_post", 64'(pulse_a), 64'd0);

        // Fill with first-word fall-through, then drain in order
        for (int i = 1; i <= 4; i++) begin
            push_a(64'(i));
            chk("fill_level", 64'(lvl_a), 64'(i));
            chk("fill_head", dout_a, 64'd1);
        end
        step();
        chk("fill_pulse_off", 64'(pulse_a), 64'd0);
        drain_a(64'd1, 64'd2, 64'd3, 64'd4);

        // Overflow at full is dropped and sticky until flush
        for (int i = 0; i < 4; i++) push_a(64'h11 + 64'(i));
        en_a = 1'b1; din_a = 64'hDEAD;
        step();
        en_a = 1'b0;
        chk("ovf_set", 64'(ovf_a), 64'd1);
        chk("ovf_level", 64'(lvl_a), 64'd4);
        chk("ovf_no_pulse", 64'(pulse_a), 64'd0);
        step();
        chk("ovf_sticky", 64'(ovf_a), 64'd1);
        drain_a(64'h11, 64'h12, 64'h13, 64'h14);
        chk("ovf_after_drain", 64'(ovf_a), 64'd1);
        flush_a = 1'b1;
        step();
        flush_a = 1'b0;
        chk("ovf_flush", 64'(ovf_a), 64'd0);

        // Simultaneous push and pop at full
        for (int i = 0; i < 4; i++) push_a(64'h21 + 64'(i));
        en_a = 1'b1; din_a = 64'h55; ready_a = 1'b1;
        step();
        en_a = 1'b0; ready_a = 1'b0;
        chk("sim_level", 64'(lvl_a), 64'd4);
        chk("sim_ovf", 64'(ovf_a), 64'd0);
        chk("sim_pulse", 64'(pulse_a), 64'd1);
        drain_a(64'h22, 64'h23, 64'h24, 64'h55);

        // Flush beats concurrent write and read
        push_a(64'h31);
        push_a(64'h32);
        chk("fl_level_pre", 64'(lvl_a), 64'd2);
        flush_a = 1'b1; en_a = 1'b1; ready_a = 1'b1; din_a = 64'h77;
        step();
        flush_a = 1'b0; en_a = 1'b0; ready_a = 1'b0;
        chk("fl_level", 64'(lvl_a), 64'd0);
        chk("fl_valid", 64'(valid_a), 64'd0);
        chk("fl_pulse", 64'(pulse_a), 64'd0);
        chk("fl_ovf", 64'(ovf_a), 64'd0);
        chk("fl_data", dout_a, 64'd0);
        step();
        chk("fl_pulse_late", 64'(pulse_a), 64'd0);

        // Wrap-around streaming on DEPTH=3
        ready_b = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            if (i > 1) chk("wrap_read", dout_b, 64'h100 + 64'(i - 1));
            en_b = 1'b1; din_b = 64'h100 + 64'(i);
            step();
            chk("wrap_level", 64'(lvl_b), 64'd1);
            chk("wrap_pulse", 64'(pulse_b), 64'd1);
        end
        en_b = 1'b0;
        chk("wrap_last", dout_b, 64'h10A);
        step();
        ready_b = 1'b0;
        chk("wrap_empty", 64'(lvl_b), 64'd0);
        chk("wrap_valid", 64'(valid_b), 64'd0);
        chk("wrap_ovf", 64'(ovf_b), 64'd0);

        // Reset mid-operation discards contents; strobe in reset cycle ignored
        push_a(64'h41);
        push_a(64'h42);
        rst_n = 1'b0; en_a = 1'b1; din_a = 64'h43;
        step();
        rst_n = 1'b1; en_a = 1'b0;
        chk("mid_rst_level", 64'(lvl_a), 64'd0);
        chk("mid_rst_valid", 64'(valid_a), 64'd0);
        chk("mid_rst_pulse", 64'(pulse_a), 64'd0);
        chk("mid_rst_data", dout_a, 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
